plugboard_cfg_ctrl: RTL and testbench

Configuration sequencer and lookup engine for the Enigma plugboard stage. It captures letter pairs from one-hot keystroke strobes into a swap table, rejecting illegal pairs, then serves one-hot letter lookups through that table in run mode. It sits between the keyboard decoder and the rotor/reflector path, and is instantiated twice (front and rear) or time-shared by the top level.

---
 rtl/plugboard_cfg_ctrl.sv | 157 +++++++++++++++
 tb/tb_plugboard_cfg_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/plugboard_cfg_ctrl.sv
// plugboard_cfg_ctrl: configuration sequencer and lookup engine for one
// Enigma plugboard stage. Letter pairs are captured from one-hot keystrokes
// into a 26-entry swap table. In RUN the table serves one-hot lookups.
// Build option: define PLUGBOARD_PRESET_EN to make reset load A<->Z, B<->Y and
// C<->X (pair_count 3). Without it, reset loads the identity table.
//
// Strobe semantics: every input strobe (cfg_start, cfg_done, key_valid,
// map_valid) is a single-cycle request that is sampled on the posedge. There is
// no back-pressure. Requests that do not apply in the current state are dropped.
// map_out_valid and cfg_err are single-cycle responses that appear one cycle
// after their request.
module plugboard_cfg_ctrl #(
    parameter int MAX_PAIRS = 10
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        cfg_start,
    input  logic        cfg_done,
    input  logic        key_valid,
    input  logic [25:0] key_letter,
    input  logic        map_valid,
    input  logic [25:0] map_in,
    output logic [25:0] map_out,
    output logic        map_out_valid,
    output logic        busy,
    output logic        pending,
    output logic [3:0]  pair_count,
    output logic        cfg_err
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_CAP_A = 2'd1;
    localparam logic [1:0] ST_CAP_B = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  tbl_q [26];
    logic [4:0]  tbl_d [26];
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  latch_q, latch_d;
    logic        err_q, err_d;
    logic [25:0] map_out_q, map_out_d;
    logic        mov_q, mov_d;

    logic        k_ok, m_ok;
    logic [4:0]  k_idx, m_idx;
    logic [3:0]  cnt_inc;

    // Encode a one-hot letter. The result is {valid, index}. Valid requires exactly one bit set.
    function automatic logic [5:0] enc(input logic [25:0] oh);
        logic [4:0] idx;
        int         n;
        idx = '0;
        n   = 0;
        for (int i = 0; i < 26; i++) begin
            if (oh[i]) begin
                idx = 5'(i);
                n   = n + 1;
            end
        end
        return {(n == 1), idx};
    endfunction

    // Table entry loaded at reset: either identity or the three preset pairs.
    function automatic logic [4:0] reset_entry(input int i);
`ifdef PLUGBOARD_PRESET_EN
        if (i <= 2 || i >= 23) return 5'(25 - i);
        else                   return 5'(i);
`else
        return 5'(i);
`endif
    endfunction

    assign {k_ok, k_idx} = enc(key_letter);
    assign {m_ok, m_idx} = enc(map_in);
    assign cnt_inc       = cnt_q + 4'd1;

    // Next-state logic. Priority is cfg_start, then cfg_done, then key_valid. Lookups run only in RUN.
    always_comb begin
        state_d   = state_q;
        tbl_d     = tbl_q;
        cnt_d     = cnt_q;
        latch_d   = latch_q;
        err_d     = 1'b0;
        map_out_d = map_out_q;
        mov_d     = 1'b0;

        if (map_valid && state_q == ST_RUN) begin
            mov_d     = 1'b1;
            map_out_d = m_ok ? (26'd1 << tbl_q[m_idx]) : '0;
        end

        if (cfg_start) begin
            for (int i = 0; i < 26; i++) tbl_d[i] = 5'(i);
            cnt_d   = '0;
            state_d = ST_CAP_A;
        end else if (state_q != ST_RUN) begin
            if (cfg_done) begin
                state_d = ST_RUN;
            end else if (key_valid) begin
                if (state_q == ST_CAP_A) begin
                    if (k_ok && tbl_q[k_idx] == k_idx) begin
                        latch_d = k_idx;
                        state_d = ST_CAP_B;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    // The latched letter is still identity in the table, so test for it first.
                    if (k_ok && k_idx == latch_q) begin
                        err_d   = 1'b1;
                        state_d = ST_CAP_A;
                    end else if (k_ok && tbl_q[k_idx] == k_idx) begin
                        tbl_d[k_idx]   = latch_q;
                        tbl_d[latch_q] = k_idx;
                        cnt_d          = cnt_inc;
                        state_d        = (cnt_inc == 4'(MAX_PAIRS)) ? ST_RUN : ST_CAP_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
        end
    end

    // State and table registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_RUN;
            for (int i = 0; i < 26; i++) tbl_q[i] <= reset_entry(i);
`ifdef PLUGBOARD_PRESET_EN
            cnt_q <= 4'd3;
`else
            cnt_q <= 4'd0;
`endif
            latch_q   <= '0;
            err_q     <= 1'b0;
            map_out_q <= '0;
            mov_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tbl_q     <= tbl_d;
            cnt_q     <= cnt_d;
            latch_q   <= latch_d;
            err_q     <= err_d;
            map_out_q <= map_out_d;
            mov_q     <= mov_d;
        end
    end

    assign map_out       = map_out_q;
    assign map_out_valid = mov_q;
    assign busy          = (state_q != ST_RUN);
    assign pending       = (state_q == ST_CAP_B);
    assign pair_count    = cnt_q;
    assign cfg_err       = err_q;

endmodule

// File: tb/tb_plugboard_cfg_ctrl.sv
// tb_plugboard_cfg_ctrl: directed steps followed by random traffic. A
// behavioural plugboard model checks the DUT after every clock edge.
module tb_plugboard_cfg_ctrl;

  localparam int MAX_PAIRS = 10;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_done = 1'b0;
  logic        key_valid = 1'b0;
  logic [25:0] key_letter = '0;
  logic        map_valid = 1'b0;
  logic [25:0] map_in = '0;
  logic [25:0] map_out;
  logic        map_out_valid;
  logic        busy;
  logic        pending;
  logic [3:0]  pair_count;
  logic        cfg_err;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state: partner letter per letter, session flag, held first letter.
  int          partner[26];
  int          m_cnt;
  bit          m_cap;
  int          held;
  bit          exp_err;
  bit          exp_mov;
  logic [25:0] exp_mo;

  plugboard_cfg_ctrl #(.MAX_PAIRS(MAX_PAIRS)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cfg_start(cfg_start), .cfg_done(cfg_done),
    .key_valid(key_valid), .key_letter(key_letter), .map_valid(map_valid), .map_in(map_in),
    .map_out(map_out), .map_out_valid(map_out_valid), .busy(busy), .pending(pending),
    .pair_count(pair_count), .cfg_err(cfg_err)
  );

  // Clock and reset.
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [25:0] ltr(input int i);
    logic [25:0] one;
    one = 26'd1;
    return one << i;
  endfunction

  function automatic logic [25:0] rand_letter();
    int r;
    r = $urandom_range(0, 99);
    if (r < 88) return ltr($urandom_range(0, 25));
    else if (r < 94) return '0;
    else return 26'($urandom) | ltr($urandom_range(0, 25)) | ltr($urandom_range(0, 25));
  endfunction

  // Scoreboard comparison.
  task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 26; i++) partner[i] = i;
`ifdef PLUGBOARD_PRESET_EN
    partner[0] = 25; partner[25] = 0;
    partner[1] = 24; partner[24] = 1;
    partner[2] = 23; partner[23] = 2;
    m_cnt = 3;
`else
    m_cnt = 0;
`endif
    m_cap = 0; held = -1; exp_err = 0; exp_mov = 0; exp_mo = '0;
  endtask

  // One clock edge of plugboard behaviour expressed through letter partners.
  task automatic model_edge(input logic cs, input logic cd, input logic kv,
                            input logic [25:0] key, input logic mv, input logic [25:0] mi);
    bit ok;
    int k;
    exp_err = 0;
    exp_mov = 0;
    if (mv && !m_cap) begin
      exp_mov = 1;
      exp_mo = ($countones(mi) == 1) ? ltr(partner[$clog2(mi)]) : '0;
    end
    if (cs) begin
      for (int i = 0; i < 26; i++) partner[i] = i;
      m_cnt = 0; m_cap = 1; held = -1;
    end else if (m_cap) begin
      if (cd) begin
        m_cap = 0; held = -1;
      end else if (kv) begin
        ok = ($countones(key) == 1);
        k = ok ? $clog2(key) : 0;
        if (held < 0) begin
          if (ok && partner[k] == k) held = k;
          else exp_err = 1;
        end else if (ok && k == held) begin
          exp_err = 1; held = -1;
        end else if (ok && partner[k] == k) begin
          partner[k] = held; partner[held] = k;
          m_cnt++; held = -1;
          if (m_cnt == MAX_PAIRS) m_cap = 0;
        end else begin
          exp_err = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    check("busy", 26'(busy), 26'(m_cap));
    check("pending", 26'(pending), 26'(held >= 0));
    check("pair_count", 26'(pair_count), 26'(m_cnt));
    check("cfg_err", 26'(cfg_err), 26'(exp_err));
    check("map_out_valid", 26'(map_out_valid), 26'(exp_mov));
    if (exp_mov) check("map_out", map_out, exp_mo);
  endtask

  // Driver tasks: drive inputs, take one edge, advance the model, compare at edge+1.
  task automatic cycle(input logic cs, input logic cd, input logic kv, input logic [25:0] key,
                       input logic mv, input logic [25:0] mi);
    cfg_start = cs; cfg_done = cd; key_valid = kv; key_letter = key;
    map_valid = mv; map_in = mi;
    @(posedge CLOCK_50);
    model_edge(cs, cd, kv, key, mv, mi);
    #1;
    check_all();
    cfg_start = 0; cfg_done = 0; key_valid = 0; key_letter = '0; map_valid = 0; map_in = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(posedge CLOCK_50);
    model_reset();
    #1;
    reset = 0;
    check_all();
  endtask

  task automatic key(input logic [25:0] l);   cycle(0, 0, 1, l, 0, '0); endtask
  task automatic lookup(input logic [25:0] l); cycle(0, 0, 0, '0, 1, l); endtask
  task automatic start();                      cycle(1, 0, 0, '0, 0, '0); endtask
  task automatic done();                       cycle(0, 1, 0, '0, 0, '0); endtask
  task automatic idle();                       cycle(0, 0, 0, '0, 0, '0); endtask

  initial begin
    // Reset state.
    do_reset();
    check("rst_map_out", map_out, 26'h0);
    check("rst_map_out_valid", 26'(map_out_valid), 26'h0);
    check("rst_cfg_err", 26'(cfg_err), 26'h0);
`ifdef PLUGBOARD_PRESET_EN
    check("rst_pair_count", 26'(pair_count), 26'd3);
    lookup(ltr(24));
    check("preset_Y", map_out, 26'h2);
    start(); done();
    lookup(ltr(24));
    check("cleared_Y", map_out, 26'h1000000);
`else
    check("rst_pair_count", 26'(pair_count), 26'd0);
    lookup(ltr(0));  check("id_A", map_out, 26'h1);
    lookup(ltr(12)); check("id_M", map_out, 26'h1000);
    lookup(ltr(25)); check("id_Z", map_out, 26'h2000000);
    idle();          check("no_valid_idle", 26'(map_out_valid), 26'h0);
`endif

    // Simple pair A-C.
    start();
    key(ltr(0)); key(ltr(2));
    done();
    check("busy_after_done", 26'(busy), 26'h0);
    lookup(ltr(0)); check("pair_A", map_out, 26'h4);
    lookup(ltr(2)); check("pair_C", map_out, 26'h1);
    check("count_1", 26'(pair_count), 26'd1);

    // Same letter twice, then a legal pair, then a paired letter as the first key.
    start();
    key(ltr(0)); key(ltr(0));
    check("same_err", 26'(cfg_err), 26'h1);
    check("same_pending", 26'(pending), 26'h0);
    key(ltr(0)); key(ltr(1));
    check("ab_count", 26'(pair_count), 26'd1);
    key(ltr(1));
    check("paired_err", 26'(cfg_err), 26'h1);
    check("paired_busy", 26'(busy), 26'h1);
    check("paired_pending", 26'(pending), 26'h0);

    // Fill to MAX_PAIRS and return to RUN without cfg_done.
    start();
    for (int i = 0; i < 2 * MAX_PAIRS; i++) key(ltr(i));
    check("full_count", 26'(pair_count), 26'(MAX_PAIRS));
    check("full_busy", 26'(busy), 26'h0);
    key(ltr(22));
    check("extra_key_err", 26'(cfg_err), 26'h0);
    check("extra_key_count", 26'(pair_count), 26'(MAX_PAIRS));
    lookup(ltr(19)); check("full_T", map_out, ltr(18));

    // cfg_done beats key_valid; two-bit key is rejected.
    start();
    key(ltr(3));
    cycle(0, 1, 1, ltr(4), 0, '0);
    check("done_wins_busy", 26'(busy), 26'h0);
    check("done_wins_pending", 26'(pending), 26'h0);
    check("done_wins_err", 26'(cfg_err), 26'h0);
    start();
    key(26'h3);
    check("twobit_err", 26'(cfg_err), 26'h1);
    lookup(ltr(5));
    check("cap_lookup_dropped", 26'(map_out_valid), 26'h0);
    done();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, 1'($urandom_range(0, 1)),
              rand_letter(), $urandom_range(0, 2) == 0, rand_letter());
      end
    end

    // Final report.
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
